// File: rtl/pic_irq_core_pkg.sv
// Package pic_pkg: shared constants, the level-ID type and the priority-rank
// helper used by the PIC request/in-service core.
//   IR_W        : number of IR lines (8)
//   ID_W        : width of a level ID (3)
//   LP_RESET    : reset value of the lowest-priority pointer (IR7 lowest)
//   SPURIOUS_ID : ID reported when INTA finds no valid request
package pic_pkg;

  localparam int IR_W = 8;
  localparam int ID_W = 3;

  typedef logic [ID_W-1:0] ir_id_t;

  localparam ir_id_t LP_RESET    = 3'd7;
  localparam ir_id_t SPURIOUS_ID = 3'd7;

  // Rank of a level relative to the lowest-priority pointer: 0 is the
  // highest priority (lp+1), 7 the lowest (lp). The 3-bit wrap does the mod 8.
  function automatic ir_id_t prio_rank(input ir_id_t id, input ir_id_t lp);
    return id - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_irq_core_if.sv
// Interface pic_irq_core_if: handshake between the PIC control logic
// (master) and the request/in-service core (slave).
//   ack1/ack2          : first/second INTA strobes from control logic
//   eoi_valid/specific : OCW2 EOI command strobe and type
//   eoi_id/eoi_rotate  : specific EOI level, rotate-on-EOI flag
//   int_req            : registered interrupt request to control logic
//   vec_valid/vec_id   : one-cycle strobe with the acknowledged level
//   highest_id         : highest-priority in-service level
interface pic_irq_core_if;
  import pic_pkg::*;

  logic   ack1;
  logic   ack2;
  logic   eoi_valid;
  logic   eoi_specific;
  ir_id_t eoi_id;
  logic   eoi_rotate;
  logic   int_req;
  logic   vec_valid;
  ir_id_t vec_id;
  ir_id_t highest_id;

  modport master (
    output ack1, ack2, eoi_valid, eoi_specific, eoi_id, eoi_rotate,
    input  int_req, vec_valid, vec_id, highest_id
  );

  modport slave (
    input  ack1, ack2, eoi_valid, eoi_specific, eoi_id, eoi_rotate,
    output int_req, vec_valid, vec_id, highest_id
  );

endinterface

// File: rtl/pic_prio_enc.sv
// pic_prio_enc: combinational rotating priority encoder.
//   vec : request vector, bit i = level i
//   lp  : lowest-priority level; lp+1 is searched first
//   id  : highest-priority set level (0 when vec is empty)
//   any : at least one bit of vec is set
module pic_prio_enc
  import pic_pkg::*;
(
  input  logic [IR_W-1:0] vec,
  input  ir_id_t          lp,
  output ir_id_t          id,
  output logic            any
);

  ir_id_t cand_s;

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    id     = 3'd0;
    any    = 1'b0;
    cand_s = 3'd0;
    for (int k = IR_W - 1; k >= 0; k--) begin
      cand_s = lp + 3'd1 + ir_id_t'(k);
      id     = vec[cand_s] ? cand_s : id;
      any    = any | vec[cand_s];
    end
  end

endmodule

// File: rtl/pic_irq_core.sv
// pic_irq_core: IR synchroniser, IRR/ISR registers and rotating,
// fully-nested priority resolution of an 8259-style PIC.
// Optional feature macro: PIC_SPECIAL_MASK_EN adds the smm port; masked
// in-service levels then stop blocking lower-priority requests.
//   clk, rst_n       : clock, asynchronous active-low reset
//   ir               : raw IR lines (asynchronous)
//   ltim             : 1 = level-triggered, 0 = edge-triggered
//   aeoi/rotate_aeoi : automatic EOI on second INTA, rotate on it
//   imr              : interrupt mask, 1 = masked
//   smm              : special mask mode (PIC_SPECIAL_MASK_EN only)
//   ctl              : control-logic handshake (slave side)
//   irr, isr         : request and in-service registers
module pic_irq_core
  import pic_pkg::*;
#(
  parameter int NUM_IR      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_IR-1:0] ir,
  input  logic              ltim,
  input  logic              aeoi,
  input  logic              rotate_aeoi,
  input  logic [NUM_IR-1:0] imr,
`ifdef PIC_SPECIAL_MASK_EN
  input  logic              smm,
`endif
  pic_irq_core_if.slave     ctl,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr
);

  logic [NUM_IR-1:0] sync_r [SYNC_STAGES];
  logic [NUM_IR-1:0] ir_s, ir_d_r, rise_s;
  logic [NUM_IR-1:0] irr_r, isr_r, irr_nxt_s, isr_nxt_s, eff_isr_s;
  logic [NUM_IR-1:0] ack_mask_s, aeoi_mask_s, eoi_mask_s;
  ir_id_t            lp_r, lp_nxt_s, ack_id_r, vec_id_r;
  ir_id_t            win_id_s, isr_hi_s, eoi_tgt_s;
  logic              win_any_s, isr_any_s, win_valid_s, smm_s;
  logic              ack_take_s, aeoi_take_s, eoi_take_s;
  logic              ack_spur_r, int_req_r, vec_valid_r;

`ifdef PIC_SPECIAL_MASK_EN
  assign smm_s = smm;
`else
  assign smm_s = 1'b0;
`endif

  assign ir_s      = sync_r[SYNC_STAGES-1];
  assign eff_isr_s = smm_s ? (isr_r & ~imr) : isr_r;

  pic_prio_enc u_win_enc (.vec(irr_r & ~imr), .lp(lp_r), .id(win_id_s), .any(win_any_s));
  pic_prio_enc u_isr_enc (.vec(eff_isr_s),    .lp(lp_r), .id(isr_hi_s), .any(isr_any_s));

  // A request only interrupts if it strictly outranks everything in service.
  assign win_valid_s = win_any_s &
                       (~isr_any_s | (prio_rank(win_id_s, lp_r) < prio_rank(isr_hi_s, lp_r)));

  // Synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= {NUM_IR{1'b0}};
      ir_d_r <= {NUM_IR{1'b0}};
    end else begin
      sync_r[0] <= ir;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
      ir_d_r <= ir_s;
    end
  end

  // Next IRR/ISR/lp from requests, INTA and EOI commands.
  always_comb begin
    ack_take_s  = ctl.ack1 & win_valid_s;
    ack_mask_s  = ack_take_s ? (NUM_IR'(1'b1) << win_id_s) : {NUM_IR{1'b0}};
    aeoi_take_s = ctl.ack2 & aeoi & ~ack_spur_r;
    aeoi_mask_s = aeoi_take_s ? (NUM_IR'(1'b1) << ack_id_r) : {NUM_IR{1'b0}};
    eoi_tgt_s   = ctl.eoi_specific ? ctl.eoi_id : isr_hi_s;
    // Non-specific EOI with nothing in service does nothing, not even rotate.
    eoi_take_s  = ctl.eoi_valid & (ctl.eoi_specific | isr_any_s);
    eoi_mask_s  = eoi_take_s ? (NUM_IR'(1'b1) << eoi_tgt_s) : {NUM_IR{1'b0}};
    rise_s      = ir_s & ~ir_d_r;
    // The ack clear wins over a same-cycle edge or level on that bit.
    irr_nxt_s   = (ltim ? ir_s : (irr_r | rise_s)) & ~ack_mask_s;
    // Clears first, then the ack set, so a same-bit set wins.
    isr_nxt_s   = (isr_r & ~eoi_mask_s & ~aeoi_mask_s) | ack_mask_s;
    if (eoi_take_s && ctl.eoi_rotate) begin
      lp_nxt_s = eoi_tgt_s;
    end else if (aeoi_take_s && rotate_aeoi) begin
      lp_nxt_s = ack_id_r;
    end else begin
      lp_nxt_s = lp_r;
    end
  end

  // Core state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr_r       <= {NUM_IR{1'b0}};
      isr_r       <= {NUM_IR{1'b0}};
      lp_r        <= LP_RESET;
      ack_id_r    <= SPURIOUS_ID;
      ack_spur_r  <= 1'b1;
      int_req_r   <= 1'b0;
      vec_valid_r <= 1'b0;
      vec_id_r    <= 3'd0;
    end else begin
      irr_r       <= irr_nxt_s;
      isr_r       <= isr_nxt_s;
      lp_r        <= lp_nxt_s;
      int_req_r   <= win_valid_s;
      vec_valid_r <= ctl.ack2;
      if (ctl.ack2) vec_id_r <= ack_id_r;
      if (ctl.ack1) begin
        ack_id_r   <= win_valid_s ? win_id_s : SPURIOUS_ID;
        ack_spur_r <= ~win_valid_s;
      end
    end
  end

  assign irr            = irr_r;
  assign isr            = isr_r;
  assign ctl.int_req    = int_req_r;
  assign ctl.vec_valid  = vec_valid_r;
  assign ctl.vec_id     = vec_id_r;
  assign ctl.highest_id = isr_hi_s;

endmodule

// File: tb/tb_pic_irq_core.sv
// Self-checking bench for pic_irq_core: a directed table, a reset-during-
// acknowledge sequence and a randomized run, all compared each cycle with
// a behavioural reference model.
module tb_pic_irq_core;
  import pic_pkg::*;

  localparam int S = 2;
  localparam int C_IRR = 1, C_ISR = 2, C_INT = 4, C_VV = 8, C_VID = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ir, imr, irr, isr;
  logic       ltim, aeoi, rotate_aeoi;
`ifdef PIC_SPECIAL_MASK_EN
  logic       smm = 1'b0;
`endif

  pic_irq_core_if bus();

  pic_irq_core #(.NUM_IR(8), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ltim(ltim), .aeoi(aeoi),
    .rotate_aeoi(rotate_aeoi), .imr(imr),
`ifdef PIC_SPECIAL_MASK_EN
    .smm(smm),
`endif
    .ctl(bus), .irr(irr), .isr(isr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  logic [7:0] hist [0:S];
  logic [7:0] m_irr, m_isr;
  int         m_lp, m_ack_id, m_vec_id;
  bit         m_spur, m_int_req, m_vec_valid;

  function automatic int best(logic [7:0] v, int lpv);
    for (int r = 0; r < 8; r++) if (v[(lpv + 1 + r) % 8]) return (lpv + 1 + r) % 8;
    return -1;
  endfunction

  function automatic int rank_of(int id, int lpv);
    return (id - lpv + 7) % 8;
  endfunction

  task automatic model_reset();
    for (int k = 0; k <= S; k++) hist[k] = 8'h00;
    m_irr = 8'h00; m_isr = 8'h00; m_lp = 7; m_ack_id = 7; m_spur = 1'b1;
    m_int_req = 1'b0; m_vec_valid = 1'b0; m_vec_id = 0;
  endtask

  task automatic model_update();
    logic [7:0] irs, ird, nirr, nisr;
    int w, h, nlp;
    bit valid;
    irs = hist[S-1];
    ird = hist[S];
    w = best(m_irr & ~imr, m_lp);
    h = best(m_isr, m_lp);
    valid = (w >= 0) && ((h < 0) || (rank_of(w, m_lp) < rank_of(h, m_lp)));
    nlp = m_lp;
    nisr = m_isr;
    for (int i = 0; i < 8; i++) nirr[i] = ltim ? irs[i] : (m_irr[i] | (irs[i] & ~ird[i]));
    if (bus.ack1 && valid) nirr[w] = 1'b0;
    if (bus.ack2 && aeoi && !m_spur) begin
      nisr[m_ack_id] = 1'b0;
      if (rotate_aeoi) nlp = m_ack_id;
    end
    if (bus.eoi_valid) begin
      if (bus.eoi_specific) begin
        nisr[bus.eoi_id] = 1'b0;
        if (bus.eoi_rotate) nlp = int'(bus.eoi_id);
      end else if (h >= 0) begin
        nisr[h] = 1'b0;
        if (bus.eoi_rotate) nlp = h;
      end
    end
    if (bus.ack1 && valid) nisr[w] = 1'b1;
    m_vec_valid = bus.ack2;
    if (bus.ack2) m_vec_id = m_ack_id;
    if (bus.ack1) begin
      m_ack_id = valid ? w : 7;
      m_spur = !valid;
    end
    m_int_req = valid;
    m_irr = nirr;
    m_isr = nisr;
    m_lp = nlp;
    for (int k = S; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = ir;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic compare_model();
    int hh;
    hh = best(m_isr, m_lp);
    check("model_irr", {24'h0, irr}, {24'h0, m_irr});
    check("model_isr", {24'h0, isr}, {24'h0, m_isr});
    check("model_int_req", {31'h0, bus.int_req}, {31'h0, m_int_req});
    check("model_vec_valid", {31'h0, bus.vec_valid}, {31'h0, m_vec_valid});
    check("model_vec_id", {29'h0, bus.vec_id}, m_vec_id);
    check("model_highest_id", {29'h0, bus.highest_id}, (hh < 0) ? 0 : hh);
  endtask

  // Inputs are set at the negedge before calling; returns at the next negedge.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare_model();
    @(negedge clk);
  endtask

  task automatic clear_cmds();
    bus.ack1 = 1'b0; bus.ack2 = 1'b0; bus.eoi_valid = 1'b0;
    bus.eoi_specific = 1'b0; bus.eoi_id = 3'd0; bus.eoi_rotate = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [7:0] ir;
    bit ltim, aeoi, rot, a1, a2, eoi, spec;
    int id;
    bit erot;
    int hold, chk;
    logic [7:0] e_irr, e_isr;
    bit e_int, e_vv;
    int e_vid;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [7:0] vir, bit vlt, bit vae, bit vro, bit a1, bit a2,
                              bit eo, bit sp, int id, bit er, int hold, int chk,
                              logic [7:0] eirr, logic [7:0] eisr, bit eint, bit evv, int evid);
    vec_t v;
    v.ir = vir; v.ltim = vlt; v.aeoi = vae; v.rot = vro; v.a1 = a1; v.a2 = a2;
    v.eoi = eo; v.spec = sp; v.id = id; v.erot = er; v.hold = hold; v.chk = chk;
    v.e_irr = eirr; v.e_isr = eisr; v.e_int = eint; v.e_vv = evv; v.e_vid = evid;
    tbl.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0; ir = 8'h00; imr = 8'h00; ltim = 1'b0; aeoi = 1'b0; rotate_aeoi = 1'b0;
    clear_cmds();
    model_reset();

    // Edge mode, lp = 7
    add(8'h24,0,0,0, 0,0,0,0,0,0, 4, C_IRR|C_ISR|C_INT, 8'h24,8'h00,1,0,0);
    add(8'h24,0,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR|C_INT, 8'h20,8'h04,1,0,0);
    add(8'h24,0,0,0, 0,1,0,0,0,0, 1, C_ISR|C_INT|C_VV|C_VID, 8'h00,8'h04,0,1,2);
    add(8'h24,0,0,0, 0,0,1,0,0,0, 1, C_ISR|C_VV, 8'h00,8'h00,0,0,0);
    add(8'h24,0,0,0, 0,0,0,0,0,0, 1, C_IRR|C_INT|C_VV, 8'h20,8'h00,1,0,0);
    add(8'h24,0,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h00,8'h20,0,0,0);
    add(8'h24,0,0,0, 0,1,0,0,0,0, 1, C_VV|C_VID, 8'h00,8'h00,0,1,5);
    add(8'h24,0,0,0, 0,0,1,1,5,0, 1, C_ISR, 8'h00,8'h00,0,0,0);
    add(8'h00,0,0,0, 0,0,0,0,0,0, 3, C_IRR|C_ISR|C_INT, 8'h00,8'h00,0,0,0);
    // Level request dropped before ack1 -> spurious
    add(8'h00,1,0,0, 0,0,0,0,0,0, 2, C_IRR, 8'h00,8'h00,0,0,0);
    add(8'h20,1,0,0, 0,0,0,0,0,0, 3, C_IRR|C_INT, 8'h20,8'h00,0,0,0);
    add(8'h00,1,0,0, 0,0,0,0,0,0, 5, C_IRR|C_INT, 8'h00,8'h00,0,0,0);
    add(8'h00,1,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h00,8'h00,0,0,0);
    add(8'h00,1,0,0, 0,1,0,0,0,0, 1, C_ISR|C_VV|C_VID, 8'h00,8'h00,0,1,7);
    // Nesting
    add(8'h00,0,0,0, 0,0,0,0,0,0, 2, C_IRR, 8'h00,8'h00,0,0,0);
    add(8'h08,0,0,0, 0,0,0,0,0,0, 4, C_IRR|C_INT, 8'h08,8'h00,1,0,0);
    add(8'h08,0,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h00,8'h08,0,0,0);
    add(8'h08,0,0,0, 0,1,0,0,0,0, 1, C_VV|C_VID, 8'h00,8'h00,0,1,3);
    add(8'h28,0,0,0, 0,0,0,0,0,0, 4, C_IRR|C_INT, 8'h20,8'h00,0,0,0);
    add(8'h2A,0,0,0, 0,0,0,0,0,0, 4, C_IRR|C_INT, 8'h22,8'h00,1,0,0);
    add(8'h2A,0,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h20,8'h0A,0,0,0);
    add(8'h2A,0,0,0, 0,1,0,0,0,0, 1, C_VV|C_VID, 8'h00,8'h00,0,1,1);
    // Non-specific EOI with rotate: lp -> 1
    add(8'h2A,0,0,0, 0,0,1,0,0,1, 1, C_ISR, 8'h00,8'h08,0,0,0);
    add(8'h00,0,0,0, 0,0,0,0,0,0, 3, C_IRR|C_INT, 8'h20,8'h00,0,0,0);
    add(8'h05,0,0,0, 0,0,0,0,0,0, 4, C_IRR|C_INT, 8'h25,8'h00,1,0,0);
    add(8'h05,0,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h21,8'h0C,0,0,0);
    add(8'h05,0,0,0, 0,1,0,0,0,0, 1, C_VV|C_VID, 8'h00,8'h00,0,1,2);
    add(8'h05,0,0,0, 0,0,1,1,2,0, 1, C_ISR, 8'h00,8'h08,0,0,0);
    add(8'h05,0,0,0, 0,0,1,1,3,0, 1, C_ISR, 8'h00,8'h00,0,0,0);
    add(8'h05,0,0,0, 0,0,0,0,0,0, 1, C_INT, 8'h00,8'h00,1,0,0);
    add(8'h05,0,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h01,8'h20,0,0,0);
    add(8'h05,0,0,0, 0,1,0,0,0,0, 1, C_VV|C_VID, 8'h00,8'h00,0,1,5);
    add(8'h05,0,0,0, 0,0,1,1,5,0, 1, C_ISR, 8'h00,8'h00,0,0,0);
    add(8'h05,0,0,0, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h00,8'h01,0,0,0);
    add(8'h05,0,0,0, 0,1,0,0,0,0, 1, C_VID, 8'h00,8'h00,0,0,0);
    add(8'h05,0,0,0, 0,0,1,0,0,0, 1, C_ISR, 8'h00,8'h00,0,0,0);
    // AEOI with rotation, and a no-op non-specific EOI that must not rotate
    add(8'h00,0,1,1, 0,0,0,0,0,0, 3, C_IRR|C_ISR|C_INT, 8'h00,8'h00,0,0,0);
    add(8'h40,0,1,1, 0,0,0,0,0,0, 4, C_IRR|C_INT, 8'h40,8'h00,1,0,0);
    add(8'h40,0,1,1, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h00,8'h40,0,0,0);
    add(8'h40,0,1,1, 0,1,0,0,0,0, 1, C_ISR|C_VV|C_VID, 8'h00,8'h00,0,1,6);
    add(8'h00,0,1,1, 0,0,0,0,0,0, 3, C_IRR|C_INT, 8'h00,8'h00,0,0,0);
    add(8'h81,0,1,1, 0,0,0,0,0,0, 4, C_IRR|C_INT, 8'h81,8'h00,1,0,0);
    add(8'h81,0,1,1, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h01,8'h80,0,0,0);
    add(8'h81,0,1,1, 0,1,0,0,0,0, 1, C_ISR|C_VID, 8'h00,8'h00,0,0,7);
    add(8'h01,0,1,1, 0,0,0,0,0,0, 2, C_IRR|C_ISR, 8'h01,8'h00,0,0,0);
    add(8'h81,0,1,1, 0,0,0,0,0,0, 4, C_IRR, 8'h81,8'h00,0,0,0);
    add(8'h81,0,1,1, 0,0,1,0,0,1, 1, C_ISR, 8'h00,8'h00,0,0,0);
    add(8'h81,0,1,1, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h80,8'h01,0,0,0);
    add(8'h81,0,1,1, 0,1,0,0,0,0, 1, C_ISR|C_VID, 8'h00,8'h00,0,0,0);
    add(8'h81,0,1,1, 1,0,0,0,0,0, 1, C_IRR|C_ISR, 8'h00,8'h80,0,0,0);
    add(8'h81,0,1,1, 0,1,0,0,0,0, 1, C_ISR|C_VID, 8'h00,8'h00,0,0,7);
    add(8'h00,0,0,0, 0,0,0,0,0,0, 3, C_IRR|C_ISR|C_INT, 8'h00,8'h00,0,0,0);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_irr", {24'h0, irr}, 32'h0);
    check("reset_isr", {24'h0, isr}, 32'h0);
    check("reset_int_req", {31'h0, bus.int_req}, 32'h0);
    check("reset_vec_valid", {31'h0, bus.vec_valid}, 32'h0);
    check("reset_vec_id", {29'h0, bus.vec_id}, 32'h0);
    check("reset_highest_id", {29'h0, bus.highest_id}, 32'h0);
    rst_n = 1'b1;

    foreach (tbl[n]) begin
      ir = tbl[n].ir; ltim = tbl[n].ltim; aeoi = tbl[n].aeoi; rotate_aeoi = tbl[n].rot;
      bus.ack1 = tbl[n].a1; bus.ack2 = tbl[n].a2; bus.eoi_valid = tbl[n].eoi;
      bus.eoi_specific = tbl[n].spec; bus.eoi_id = 3'(tbl[n].id); bus.eoi_rotate = tbl[n].erot;
      for (int c = 0; c < tbl[n].hold; c++) step();
      clear_cmds();
      if ((tbl[n].chk & C_IRR) != 0) check($sformatf("vec%0d_irr", n), {24'h0, irr}, {24'h0, tbl[n].e_irr});
      if ((tbl[n].chk & C_ISR) != 0) check($sformatf("vec%0d_isr", n), {24'h0, isr}, {24'h0, tbl[n].e_isr});
      if ((tbl[n].chk & C_INT) != 0) check($sformatf("vec%0d_int_req", n), {31'h0, bus.int_req}, {31'h0, tbl[n].e_int});
      if ((tbl[n].chk & C_VV) != 0) check($sformatf("vec%0d_vec_valid", n), {31'h0, bus.vec_valid}, {31'h0, tbl[n].e_vv});
      if ((tbl[n].chk & C_VID) != 0) check($sformatf("vec%0d_vec_id", n), {29'h0, bus.vec_id}, tbl[n].e_vid);
    end

    // Reset between ack1 and ack2
    ir = 8'h10;
    repeat (4) step();
    check("rst_seq_int_req", {31'h0, bus.int_req}, 32'h1);
    bus.ack1 = 1'b1;
    step();
    bus.ack1 = 1'b0;
    check("rst_seq_isr", {24'h0, isr}, 32'h10);
    ir = 8'h00;
    bus.ack2 = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #2;
    check("midrst_irr", {24'h0, irr}, 32'h0);
    check("midrst_isr", {24'h0, isr}, 32'h0);
    check("midrst_int_req", {31'h0, bus.int_req}, 32'h0);
    check("midrst_vec_id", {29'h0, bus.vec_id}, 32'h0);
    check("midrst_highest_id", {29'h0, bus.highest_id}, 32'h0);
    @(posedge clk);
    #1;
    check("midrst_vec_valid", {31'h0, bus.vec_valid}, 32'h0);
    @(negedge clk);
    bus.ack2 = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    check("postrst_vec_valid", {31'h0, bus.vec_valid}, 32'h0);

    // Randomized run against the model
    begin
      bit pend = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        clear_cmds();
        if (cyc % 200 == 0) begin
          ltim = 1'($urandom_range(0, 1));
          aeoi = 1'($urandom_range(0, 1));
          rotate_aeoi = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
        if ($urandom_range(0, 15) == 0) imr = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
        if (pend) begin
          bus.ack2 = ($urandom_range(0, 7) != 0);
          pend = 1'b0;
        end else if ($urandom_range(0, 4) == 0) begin
          bus.ack1 = 1'b1;
          pend = 1'b1;
        end
        if ($urandom_range(0, 6) == 0) begin
          bus.eoi_valid = 1'b1;
          bus.eoi_specific = 1'($urandom_range(0, 1));
          bus.eoi_id = 3'($urandom_range(0, 7));
          bus.eoi_rotate = 1'($urandom_range(0, 1));
        end
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pic_irq_core.md
# pic_irq_core

Interrupt request/in-service core of the 8259-style PIC, sitting directly upstream of the control logic. It synchronises the eight IR lines, holds the interrupt request register (IRR) and in-service register (ISR), and resolves rotating, fully-nested priority under the OCW1 mask. It supplies the control logic with the interrupt request, the highest-priority ID and the vector-ready strobe, and it executes that block's INTA and EOI commands.

## Interface
Parameters:
- NUM_IR, 8: number of IR lines. Fixed at 8; all ID fields are 3 bits.
- SYNC_STAGES, 2: flops in the IR input synchroniser. Minimum 2.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ir  in  8  raw IR request lines; asynchronous to clk.
- ltim  in  1  1 = level-triggered, 0 = edge-triggered (ICW1).
- aeoi  in  1  automatic EOI enable (ICW4).
- rotate_aeoi  in  1  rotate priority on automatic EOI.
- imr  in  8  mask register (OCW1); 1 = masked.
- ack1  in  1  one-cycle strobe marking the first INTA.
- ack2  in  1  one-cycle strobe marking the second INTA.
- eoi_valid  in  1  one-cycle EOI command strobe (OCW2).
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
- eoi_id  in  3  target level for a specific EOI.
- eoi_rotate  in  1  rotate priority to the level the EOI clears.
- smm  in  1  special mask mode. Present only when PIC_SPECIAL_MASK_EN is defined.
- irr  out  8  IRR contents, readable through OCW3.
- isr  out  8  ISR contents, readable through OCW3.
- highest_id  out  3  highest-priority set ISR bit. Used for non-specific EOI.
- int_req  out  1  registered INT request.
- vec_valid  out  1  one-cycle strobe: vec_id is valid for the vector.
- vec_id  out  3  acknowledged level.

## Operation
- **Synchroniser.**
  - Each ir bit passes through SYNC_STAGES flops, giving ir_s.
  - The previous value of ir_s is kept as ir_d.
- **Edge mode** (ltim = 0):
  - irr[i] sets when ir_s[i] = 1 and ir_d[i] = 0.
  - It stays set until acknowledged.
  - A level that is held high does not re-trigger.
- **Level mode** (ltim = 1):
  - irr[i] sets while ir_s[i] = 1.
  - irr[i] clears when ir_s[i] falls, unless the level is acknowledged in that same cycle.
- **Priority.**
  - A rotation pointer lp (3 bits) names the lowest-priority level. It resets to 7, so IR0 is highest.
  - Priority order is (lp+1) mod 8 first, descending through lp last.
- **Winner.** The winner is the highest-priority bit of (irr & ~imr).
  - It is valid only if it has higher priority than highest_id of the effective ISR.
  - The effective ISR is isr, or isr & ~imr when smm = 1.
  - If the effective ISR is zero, any winner is valid.
- **int_req.** Registered each cycle as (winner valid).
- **ack1.**
  - Latches ack_id = winner, sets isr[ack_id] and clears irr[ack_id].
  - If there is no valid winner (spurious interrupt), ack_id = 7 and neither isr nor irr changes.
  - int_req deasserts on the following cycle unless another higher-priority winner exists.
- **ack2.**
  - Next cycle: vec_valid = 1 and vec_id = ack_id.
  - If aeoi = 1 and the acknowledge was not spurious, clear isr[ack_id].
  - If additionally rotate_aeoi = 1, set lp = ack_id.
- **eoi_valid.**
  - Target is eoi_id when eoi_specific = 1, otherwise highest_id.
  - Clear isr[target]. If eoi_rotate = 1, set lp = target.
  - A non-specific EOI with isr = 0 is a no-op: no rotation.
- **Simultaneous events.**
  - EOI clear and ack1 set in the same cycle: both apply. If they hit the same bit, the set wins.
  - Edge arrival and ack1 on the same bit in the same cycle: the ack clears the bit and the new edge is lost.
  - ack2 with AEOI and eoi_valid in the same cycle: both clears apply. The EOI rotation takes precedence for lp.
- **ack1 without a following ack2:** no timeout. ack_id holds until the next ack1.

## Timing
- **Reset values:** irr = 0, isr = 0, highest_id = 0, int_req = 0, vec_valid = 0, vec_id = 0, lp = 7, ack_id = 7, synchroniser flops = 0.
- **Request latency:** ir rises, irr sets SYNC_STAGES+1 edges later, and int_req asserts one edge after that. With the defaults, int_req is high after edge 4.
- **ack1:** isr and irr update at the sampling edge.
- **ack2:** vec_valid pulses for exactly one cycle, starting on the edge that samples ack2.
- **EOI:** effective at the sampling edge. int_req reflects the new state one cycle later.
- **Reset mid-operation:** all state returns to reset values immediately. No vec_valid is issued for a pending ack.

## Configuration
- **PIC_SPECIAL_MASK_EN defined:**
  - The smm port exists.
  - In-service bits that are masked do not block lower-priority levels.
- **Undefined:**
  - The smm port is absent.
  - Behaviour is identical to smm = 0.

## Structure
- **Package pic_pkg:**
  - Constants: IR_W = 8, ID_W = 3, LP_RESET = 3'd7, SPURIOUS_ID = 3'd7.
  - Typedef: ir_id_t.
  - Function: priority rank of an ID relative to lp.
- **Sub-module pic_prio_enc:**
  - Combinational rotating priority encoder with inputs (vec[7:0], lp) and outputs (id, any).
  - Instantiated twice: once for the IRR winner, once for the effective ISR highest bit.

## Test plan
- **Edge mode, lp = 7:** ir = 8'h24. Required: irr = 8'h24 and int_req = 1. On ack1, isr = 8'h04 and irr = 8'h20. On ack2, vec_id = 2.
- **Level request dropped before ack1:** ltim = 1, ir[5] pulses high for 3 cycles and then drops. ack1 then gives spurious handling: ack2 yields vec_id = 7 and isr = 0.
- **Nesting:** isr = 8'h08 (IR3 in service), IR5 requested. Required: int_req = 0. Then IR1 is requested. Required: int_req = 1.
- **Non-specific EOI with rotate:** isr = 8'h0A, eoi_rotate = 1. Required: isr = 8'h08 and lp = 1. The IR2 request then outranks IR0.
- **AEOI:** aeoi = 1 and rotate_aeoi = 1, IR6 acknowledged. Required: isr = 0 after ack2 and lp = 6.
- **Reset mid-acknowledge:** assert rst_n = 0 between ack1 and ack2. Required: all outputs at reset values and no vec_valid.
